// File: rtl/signed_display_ctrl_pkg.sv
// Shared types and constants for the signed 7-segment display controller.
package display_pkg;

    localparam int DATA_W       = 10;
    localparam int BCD_DIGITS   = 3;
    localparam int SHIFT_CYCLES = 10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        SHIFT,
        DECODE,
        DONE
    } state_t;

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/signed_display_ctrl_if.sv
// Load/busy handshake plus the four HEX display buses.
interface signed_display_ctrl_if;
    import display_pkg::*;

    logic [DATA_W-1:0] value;
    logic              load;
    logic              busy;
    logic              done;
    logic [6:0]        HEX0;
    logic [6:0]        HEX1;
    logic [6:0]        HEX2;
    logic [6:0]        HEX3;

    modport master (
        output value, load,
        input  busy, done, HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  value, load,
        output busy, done, HEX0, HEX1, HEX2, HEX3
    );

endinterface

// File: rtl/signed_display_ctrl_bcd_seg_lut.sv
// Combinational BCD digit to active-low 7-segment decoder.
module bcd_seg_lut
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = 7'b1000000;
            4'd1: o_seg = 7'b1111001;
            4'd2: o_seg = 7'b0100100;
            4'd3: o_seg = 7'b0110000;
            4'd4: o_seg = 7'b0011001;
            4'd5: o_seg = 7'b0010010;
            4'd6: o_seg = 7'b0000010;
            4'd7: o_seg = 7'b1111000;
            4'd8: o_seg = 7'b0000000;
            4'd9: o_seg = 7'b0011000;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/signed_display_ctrl.sv
// Sequential signed-value display controller: abs, double-dabble, shared decode,
// then an atomic commit of all four HEX displays.
module signed_display_ctrl
    import display_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
)(
    input  logic                  clk,
    input  logic                  rst,
    signed_display_ctrl_if.slave  bus
);

    state_t            r_state;
    logic [DATA_W-1:0] r_val;
    logic              r_neg;
    logic [DATA_W-1:0] r_mag;
    logic [11:0]       r_bcd;
    logic [3:0]        r_cnt;
    logic [1:0]        r_idx;
    logic [6:0]        r_stg [2];
    logic [6:0]        r_hex0;
    logic [6:0]        r_hex1;
    logic [6:0]        r_hex2;
    logic [6:0]        r_hex3;
    logic              r_busy;
    logic              r_done;

    logic [3:0]        w_nibble;
    logic [6:0]        w_seg;
    logic [6:0]        w_digit;
    logic [11:0]       w_adj;
    logic              w_hundZero;
    logic              w_tensZero;

    assign w_adj      = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    assign w_hundZero = (r_bcd[11:8] == 4'd0);
    assign w_tensZero = (r_bcd[7:4] == 4'd0);

    always_comb begin
        w_nibble = r_bcd[3:0];
        case (r_idx)
            2'd1:    w_nibble = r_bcd[7:4];
            2'd2:    w_nibble = r_bcd[11:8];
            default: w_nibble = r_bcd[3:0];
        endcase
    end

    bcd_seg_lut u_lut (
        .i_bcd (w_nibble),
        .o_seg (w_seg)
    );

    // Ones digit is never blanked so zero still shows a single 0.
    always_comb begin
        w_digit = w_seg;
        if (BLANK_LZ) begin
            if (r_idx == 2'd2 && w_hundZero)
                w_digit = SEG_BLANK;
            else if (r_idx == 2'd1 && w_hundZero && w_tensZero)
                w_digit = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_val    <= '0;
            r_neg    <= 1'b0;
            r_mag    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_stg[0] <= '0;
            r_stg[1] <= '0;
            r_hex0   <= SEG_BLANK;
            r_hex1   <= SEG_BLANK;
            r_hex2   <= SEG_BLANK;
            r_hex3   <= SEG_BLANK;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_val   <= bus.value;
                        r_busy  <= 1'b1;
                        r_state <= ABS;
                    end
                end
                ABS: begin
                    r_neg   <= r_val[DATA_W-1];
                    r_mag   <= r_val[DATA_W-1] ? (~r_val + 10'd1) : r_val;
                    r_bcd   <= '0;
                    r_cnt   <= 4'(SHIFT_CYCLES - 1);
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    {r_bcd, r_mag} <= {w_adj[10:0], r_mag, 1'b0};
                    if (r_cnt == 4'd0) begin
                        r_idx   <= 2'd0;
                        r_state <= DECODE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DECODE: begin
                    // Hundreds goes straight to HEX2 so all four displays commit on one edge.
                    case (r_idx)
                        2'd0: begin
                            r_stg[0] <= w_digit;
                            r_idx    <= 2'd1;
                        end
                        2'd1: begin
                            r_stg[1] <= w_digit;
                            r_idx    <= 2'd2;
                        end
                        default: begin
                            r_hex0  <= r_stg[0];
                            r_hex1  <= r_stg[1];
                            r_hex2  <= w_digit;
                            r_hex3  <= r_neg ? SEG_MINUS : SEG_BLANK;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.HEX0 = r_hex0;
    assign bus.HEX1 = r_hex1;
    assign bus.HEX2 = r_hex2;
    assign bus.HEX3 = r_hex3;

endmodule

// File: tb/tb_signed_display_ctrl.sv
// Scoreboard bench for signed_display_ctrl; two instances cover both blanking modes.
module tb_signed_display_ctrl;
    import display_pkg::*;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    typedef struct {
        int                     due;
        logic [1:0][3:0][6:0]   hex;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    signed_display_ctrl_if busA ();
    signed_display_ctrl_if busB ();

    signed_display_ctrl #(.BLANK_LZ(1'b1)) dutA (.clk(clk), .rst(rst), .bus(busA.slave));
    signed_display_ctrl #(.BLANK_LZ(1'b0)) dutB (.clk(clk), .rst(rst), .bus(busB.slave));

    exp_t                 q [$];
    logic [3:0][6:0]      holdHex [2];
    logic [3:0][6:0]      actHex [2];
    logic                 actDone [2];
    logic                 actBusy [2];
    int                   busyStart = 0;
    int                   busyEnd = -1;
    int                   resetAt = -100;
    bit                   monOn = 1'b0;
    bit                   dueNow;

    assign actHex[0]  = {busA.HEX3, busA.HEX2, busA.HEX1, busA.HEX0};
    assign actHex[1]  = {busB.HEX3, busB.HEX2, busB.HEX1, busB.HEX0};
    assign actDone[0] = busA.done;
    assign actDone[1] = busB.done;
    assign actBusy[0] = busA.busy;
    assign actBusy[1] = busB.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain decimal arithmetic on the magnitude.
    function automatic logic [3:0][6:0] modelHex(input logic [9:0] v, input bit blankLz);
        int m, h, t, o;
        logic [3:0][6:0] r;
        m = v[9] ? 1024 - int'(v) : int'(v);
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        r[0] = SEG_TAB[o];
        r[1] = (blankLz && h == 0 && t == 0) ? SEG_BLANK : SEG_TAB[t];
        r[2] = (blankLz && h == 0) ? SEG_BLANK : SEG_TAB[h];
        r[3] = v[9] ? SEG_MINUS : SEG_BLANK;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic gotoCycle(input int c);
        while (cyc < c - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input logic [9:0] v, output int n);
        exp_t e;
        @(posedge clk); #1;
        n = cyc;
        busA.value = v; busB.value = v;
        busA.load = 1'b1; busB.load = 1'b1;
        if (n >= busyEnd + 1) begin
            e.due    = n + 15;
            e.hex[0] = modelHex(v, 1'b1);
            e.hex[1] = modelHex(v, 1'b0);
            q.push_back(e);
            busyStart = n + 1;
            busyEnd   = n + 15;
        end
        @(posedge clk); #1;
        busA.load = 1'b0; busB.load = 1'b0;
        busA.value = 10'($urandom); busB.value = busA.value;
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst = 1'b1;
        resetAt = cyc + 1;
        busyEnd = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: pops an expectation whenever a commit is due, otherwise checks hold.
    always @(negedge clk) begin
        if (monOn) begin
            if (cyc == resetAt) begin
                q.delete();
                holdHex[0] = {4{SEG_BLANK}};
                holdHex[1] = {4{SEG_BLANK}};
            end
            dueNow = (q.size() > 0) && (q[0].due == cyc);
            for (int d = 0; d < 2; d++) begin
                if (dueNow) begin
                    checkOutput($sformatf("done_pulse_dut%0d", d), int'(actDone[d]), 1);
                    for (int k = 0; k < 4; k++)
                        checkOutput($sformatf("commit_dut%0d_HEX%0d", d, k),
                                    int'(actHex[d][k]), int'(q[0].hex[d][k]));
                end else begin
                    checkOutput($sformatf("no_done_dut%0d", d), int'(actDone[d]), 0);
                    for (int k = 0; k < 4; k++)
                        checkOutput($sformatf("hold_dut%0d_HEX%0d", d, k),
                                    int'(actHex[d][k]), int'(holdHex[d][k]));
                end
                checkOutput($sformatf("busy_dut%0d", d), int'(actBusy[d]),
                            int'(cyc >= busyStart && cyc <= busyEnd));
            end
            if (dueNow) begin
                holdHex[0] = q[0].hex[0];
                holdHex[1] = q[0].hex[1];
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int dummy;
        int target;
        rst = 1'b1;
        busA.load = 1'b0; busB.load = 1'b0;
        busA.value = '0;  busB.value = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        resetAt = cyc;
        monOn = 1'b1;
        repeat (5) begin @(posedge clk); #1; end

        applyStimulus(10'd123, n);   gotoCycle(busyEnd + 1);
        applyStimulus(10'h200, n);   gotoCycle(busyEnd + 1);
        applyStimulus(10'd0, n);     gotoCycle(busyEnd + 1);
        applyStimulus(10'h3FF, n);   gotoCycle(busyEnd + 1);

        applyStimulus(10'd45, n);
        gotoCycle(n + 5);
        applyStimulus(10'd300, dummy);
        gotoCycle(busyEnd + 1);

        applyStimulus(10'd200, n);
        gotoCycle(n + 7);
        applyReset();
        applyStimulus(10'd7, n);
        gotoCycle(busyEnd + 1);

        // Random loads landing around the DONE / first-IDLE boundary or mid-conversion.
        repeat (30) begin
            target = busyEnd + int'($urandom_range(0, 6)) - 2;
            if ($urandom_range(0, 4) == 0)
                target = busyEnd - int'($urandom_range(3, 12));
            gotoCycle(target);
            applyStimulus(10'($urandom), dummy);
        end

        gotoCycle(busyEnd + 4);
        checkOutput("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_display_ctrl.md
# signed_display_ctrl

- Sequential display controller for the 10-bit datapath.
- Accepts a 10-bit two's-complement value over a load/busy handshake.
- Converts its magnitude to three BCD digits with an iterative shift-add-3 (double-dabble) engine.
- Runs one shared BCD-to-segment decoder over the three digits.
- Commits all four active-low 7-segment outputs (3 digits + sign) atomically, so the board HEX displays never show a partially updated number.

## Interface

Parameters:
- BLANK_LZ, 1, when 1 suppress leading-zero digits (ones digit never blanked)

Ports:
- clk  input  1  rising-edge clock; reset is synchronous and active-high
- rst  input  1  synchronous active-high reset
- value  input  10  two's-complement operand, sampled on an accepted load
- load  input  1  request conversion; accepted only when busy=0
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when new HEX values are committed
- HEX0  output  7  ones digit, active-low segments
- HEX1  output  7  tens digit, active-low segments
- HEX2  output  7  hundreds digit, active-low segments
- HEX3  output  7  sign: 7'b0111111 if negative, else 7'b1111111

## Operation

States and transitions: IDLE -> ABS -> SHIFT -> DECODE -> DONE -> IDLE.

- IDLE: load=1 captures value into val_q and moves to ABS. load=0 stays in IDLE.
- ABS: compute neg_q = val_q[9] and mag_q = neg_q ? (~val_q + 1) : val_q as a 10-bit unsigned magnitude. -512 yields 512, which is correct. Clear the 12-bit BCD register, set bit counter = 9, go to SHIFT.
- SHIFT: 10 cycles. Each cycle:
  - add 3 to every BCD nibble that is >= 5;
  - shift {bcd, mag} left by 1;
  - decrement the counter.
  - After the cycle where counter = 0, go to DECODE.
  - Maximum result is 512, so the hundreds nibble never exceeds 5.
- DECODE: 3 cycles, digit index 0,1,2 (ones, tens, hundreds).
  - The nibble is routed through the single shared decoder instance.
  - The result is written to staging register stg[index], after leading-zero blanking:
    - BLANK_LZ=1: hundreds = 0 -> 7'b1111111; tens blanked if hundreds = 0 and tens = 0.
    - BLANK_LZ=0: all three digits are always shown.
  - After index 2, go to DONE.
- DONE: one cycle. done=1. HEX0..HEX2 hold stg and HEX3 holds the sign pattern; all four were loaded on the edge entering DONE. Then return to IDLE.

Outputs:
- HEX outputs change only on the edge entering DONE and otherwise hold their last value.
- Decoder nibble codes 10-15 produce 7'b1111111 (unreachable; covers defensive states).

## Timing

- Reset, on any cycle and any state including mid-SHIFT or mid-DECODE:
  - state = IDLE;
  - busy = 0, done = 0;
  - HEX0..HEX3 = 7'b1111111;
  - staging, counters, val_q, mag_q and BCD registers cleared.
  - rst has priority over load on the same edge.
- Latency: load sampled on edge E0.
  - ABS occupies cycle 1, SHIFT cycles 2-11, DECODE cycles 12-14.
  - DONE is cycle 15: done=1 and new HEX values are visible from edge E15.
- busy goes high the cycle after the accepted load edge and falls on the edge leaving DONE. Back-to-back conversions therefore start every 16 cycles.
- load while busy=1 is ignored: no queueing, no effect on the conversion in flight.
- load asserted in the DONE cycle is ignored. load asserted in the first IDLE cycle after DONE is accepted.
- value is sampled only on the accepting edge. Later changes to value do not affect the result.

## Structure

- Package display_pkg holds:
  - the state enum (IDLE, ABS, SHIFT, DECODE, DONE);
  - constants SEG_BLANK = 7'b1111111 and SEG_MINUS = 7'b0111111;
  - constant DATA_W = 10;
  - constants BCD_DIGITS = 3 and SHIFT_CYCLES = 10.
- One sub-module, bcd_seg_lut:
  - purely combinational, 4-bit BCD in -> 7-bit active-low segments out;
  - 0-9 map to the standard team encoding (0 = 7'b1000000 ... 9 = 7'b0011000), 10-15 map to SEG_BLANK;
  - instantiated exactly once in signed_display_ctrl.

## Test plan

- Reset, then idle 5 cycles -> busy=0, done=0, HEX0..HEX3 = 7'b1111111.
- value=10'd123, load one cycle -> done pulses exactly 15 cycles later with:
  - HEX2 = 7'b1111001, HEX1 = 7'b0100100, HEX0 = 7'b0110000, HEX3 = 7'b1111111.
- value=10'b1000000000 (-512) -> HEX2 = 7'b0010010, HEX1 = 7'b1111001, HEX0 = 7'b0100100, HEX3 = 7'b0111111.
- value=0 and value=10'h3FF (-1), BLANK_LZ=1:
  - 0 -> HEX2/HEX1 blank, HEX0 = 7'b1000000, HEX3 blank;
  - -1 -> HEX0 = 7'b1111001, HEX3 = 7'b0111111.
  - Repeat value=0 with BLANK_LZ=0 -> HEX2 = HEX1 = HEX0 = 7'b1000000.
- Load 10'd45, then pulse load with 10'd300 at cycle 5 -> the second load is ignored; result shows 45 (HEX1 = 7'b0011001, HEX0 = 7'b0010010, HEX2 blank).
- Load 10'd200, assert rst at cycle 7 (mid-SHIFT) -> next cycle busy=0, HEX all blank, no done pulse. A subsequent load of 10'd7 completes normally in 15 cycles.
